wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  - 32x32 MIPS general-purpose register file; the consumer end of the MEM/WB write-back interface.
//  - Accepts one write per cycle from the WB stage (wr_regwr / wr_data / wr_regdst_addr).
//  - Serves two combinational read ports to the ID stage (rs, rt) and one debug read port.
//  - Internal WB->ID bypass, so ID sees a value in the same cycle that WB writes it.
// PARAMETERS
//  - DATA_W   32  register width
//  - ADDR_W   5   register index width
//  - NUM_REGS 32  register count; index 0 is hardwired to zero
// PORTS
//  - clk             in   1       single clock; all state updates on posedge
//  - reset           in   1       synchronous, active-high
//  - wr_regwr        in   1       WB write enable
//  - wr_data         in   32      WB write data
//  - wr_regdst_addr  in   5       WB destination register
//  - id_rs_addr      in   5       ID read port A address
//  - id_rt_addr      in   5       ID read port B address
//  - id_rs_data      out  32      ID read port A data (combinational)
//  - id_rt_data      out  32      ID read port B data (combinational)
//  - dbg_addr        in   5       debug read address
//  - dbg_data        out  32      debug read data (combinational, no bypass)
//  - wr_count        out  32      count of committed non-$0 writes since reset
// BEHAVIOUR
//  - Reset is synchronous, active-high. At a posedge with reset=1:
//    - all 32 registers <= 0; wr_count <= 0
//    - any WB write in that cycle is dropped
//  - While reset=1, id_rs_data, id_rt_data and dbg_data are forced to 0 (combinational mask).
//  - Write: at posedge, if !reset && wr_regwr && wr_regdst_addr!=0:
//    - regs[wr_regdst_addr] <= wr_data
//    - wr_count <= wr_count+1; wraps 0xFFFFFFFF -> 0
//  - A write to $0 is ignored: $0 stays 0 and wr_count is unchanged.
//  - Read ports A and B, evaluated in priority order:
//    - addr==0 -> 0
//    - else if wr_regwr && wr_regdst_addr==addr -> wr_data (same-cycle bypass)
//    - else regs[addr]
//  - Read latency is 0 cycles. A written value is visible on the ID ports in the same cycle via bypass, and from the array in the following cycle.
//  - rs==rt is allowed: both ports return identical data, including the bypassed value.
//  - dbg_data reads the array only, never the bypass. It shows a new value from the cycle after the write.
//  - Pipeline stalls live upstream in the MEM/WB register. The register file itself has no stall input: a held WB entry simply rewrites the same value, and each such cycle increments wr_count.
//  - X on wr_data with wr_regwr=0 must never propagate to any output.
// STRUCTURE
//  - Shared include regfile_defs.vh:
//    - REG_ZERO = 5'd0, NUM_REGS = 32, DATA_W = 32
//    - also used by the ID decode and forwarding unit
//  - Sub-module rf_read_port (addr, array word, wr bypass signals, reset -> data), instantiated 3x:
//    - bypass enabled for rs and rt
//    - bypass tied off for dbg
//  - Storage is a reg array with a single always @(posedge clk) block for reset, write and counter.
// TESTING
//  - Reset: hold reset 1 cycle with wr_regwr=1, addr 5, data 0xDEAD -> regs all 0, wr_count 0, reg5 reads 0 afterwards.
//  - Write/read: write r7=0x12345678; next cycle rs=7 -> 0x12345678; dbg=7 -> 0x12345678; wr_count=1.
//  - Bypass: wr_regwr=1, addr 9, data 0xCAFEBABE, rs=rt=9 in the same cycle:
//    - id_rs_data = id_rt_data = 0xCAFEBABE
//    - dbg=9 still shows the old value
//  - $0: write addr 0 data 0xFFFFFFFF -> rs=0 reads 0 both same cycle and next; wr_count unchanged.
//  - Counter wrap: force wr_count to 0xFFFFFFFF, write r1 -> wr_count 0.
//  - Random: 10k random writes/reads vs scoreboard model, including back-to-back same-address writes and reset asserted mid-stream.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared sizing and types for the MIPS general-purpose register file and its
// consumers (ID decode, forwarding unit).
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus plus the ID-stage and debug read ports of the register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic  wr_regwr;
  word_t wr_data;
  addr_t wr_regdst_addr;
  addr_t id_rs_addr;
  addr_t id_rt_addr;
  word_t id_rs_data;
  word_t id_rt_data;
  addr_t dbg_addr;
  word_t dbg_data;
  word_t wr_count;

  modport master (
    output wr_regwr, wr_data, wr_regdst_addr, id_rs_addr, id_rt_addr, dbg_addr,
    input  id_rs_data, id_rt_data, dbg_data, wr_count
  );

  modport slave (
    input  wr_regwr, wr_data, wr_regdst_addr, id_rs_addr, id_rt_addr, dbg_addr,
    output id_rs_data, id_rt_data, dbg_data, wr_count
  );

endinterface

// File: rtl/wb_regfile_rf_read_port.sv
// One combinational read port: $0 and reset force zero, optional same-cycle
// WB bypass, otherwise the stored array word.
module wb_regfile_rf_read_port
  import wb_regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic  reset,
  input  addr_t addr,
  input  word_t array_word,
  input  logic  wr_regwr,
  input  addr_t wr_addr,
  input  word_t wr_data,
  output word_t data
);

  // The bypass mux is gated by wr_regwr so an undriven wr_data never leaks out.
  always_comb begin
    data = '0;
    if (reset || addr == REG_ZERO) begin
      data = '0;
    end else if (BYPASS && wr_regwr && wr_addr == addr) begin
      data = wr_data;
    end else begin
      data = array_word;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 MIPS register file: one WB write per cycle, two bypassed ID read
// ports, one array-only debug port and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  word_t regs [NUM_REGS];
  word_t wr_cnt;

  // Entry 0 is never written, so it holds the zero loaded at reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (bus.wr_regwr && bus.wr_regdst_addr != REG_ZERO) begin
      regs[bus.wr_regdst_addr] <= bus.wr_data;
      wr_cnt                   <= wr_cnt + 32'd1;
    end
  end

  assign bus.wr_count = wr_cnt;

  wb_regfile_rf_read_port #(.BYPASS(1'b1)) u_rs_port (
    .reset      (reset),
    .addr       (bus.id_rs_addr),
    .array_word (regs[bus.id_rs_addr]),
    .wr_regwr   (bus.wr_regwr),
    .wr_addr    (bus.wr_regdst_addr),
    .wr_data    (bus.wr_data),
    .data       (bus.id_rs_data)
  );

  wb_regfile_rf_read_port #(.BYPASS(1'b1)) u_rt_port (
    .reset      (reset),
    .addr       (bus.id_rt_addr),
    .array_word (regs[bus.id_rt_addr]),
    .wr_regwr   (bus.wr_regwr),
    .wr_addr    (bus.wr_regdst_addr),
    .wr_data    (bus.wr_data),
    .data       (bus.id_rt_data)
  );

  wb_regfile_rf_read_port #(.BYPASS(1'b0)) u_dbg_port (
    .reset      (reset),
    .addr       (bus.dbg_addr),
    .array_word (regs[bus.dbg_addr]),
    .wr_regwr   (1'b0),
    .wr_addr    (REG_ZERO),
    .wr_data    ('0),
    .data       (bus.dbg_data)
  );

endmodule
